// File: rtl/sauria_axi_lite_to_obi_if.sv
// Bus bundle between an AXI4-Lite manager, the AXI-Lite-to-OBI bridge and an
// OBI memory. The slave modport is the bridge's view (AXI responder and
// OBI initiator); the master modport is the view of the surrounding system.
interface sauria_axi_lite_to_obi_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // AXI4-Lite write address / data / response
    logic [ADDR_WIDTH-1:0] aw_addr_i;
    logic                  aw_valid_i;
    logic                  aw_ready_o;
    logic [DATA_WIDTH-1:0] w_data_i;
    logic [BE_WIDTH-1:0]   w_strb_i;
    logic                  w_valid_i;
    logic                  w_ready_o;
    logic [1:0]            b_resp_o;
    logic                  b_valid_o;
    logic                  b_ready_i;

    // AXI4-Lite read address / data
    logic [ADDR_WIDTH-1:0] ar_addr_i;
    logic                  ar_valid_i;
    logic                  ar_ready_o;
    logic [DATA_WIDTH-1:0] r_data_o;
    logic [1:0]            r_resp_o;
    logic                  r_valid_o;
    logic                  r_ready_i;

    // OBI initiator
    logic                  obi_req_o;
    logic                  obi_gnt_i;
    logic [ADDR_WIDTH-1:0] obi_addr_o;
    logic                  obi_we_o;
    logic [BE_WIDTH-1:0]   obi_be_o;
    logic [DATA_WIDTH-1:0] obi_wdata_o;
    logic                  obi_rvalid_i;
    logic [DATA_WIDTH-1:0] obi_rdata_i;

    modport slave (
        input  aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
        input  ar_addr_i, ar_valid_i, r_ready_i,
        input  obi_gnt_i, obi_rvalid_i, obi_rdata_i,
        output aw_ready_o, w_ready_o, b_resp_o, b_valid_o,
        output ar_ready_o, r_data_o, r_resp_o, r_valid_o,
        output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o
    );

    modport master (
        output aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
        output ar_addr_i, ar_valid_i, r_ready_i,
        output obi_gnt_i, obi_rvalid_i, obi_rdata_i,
        input  aw_ready_o, w_ready_o, b_resp_o, b_valid_o,
        input  ar_ready_o, r_data_o, r_resp_o, r_valid_o,
        input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o
    );
endinterface

// File: rtl/sauria_axi_lite_to_obi.sv
// Single-outstanding AXI4-Lite responder that turns each read or write into
// exactly one OBI transaction. Reads and writes are serialised through one
// FSM; when both are offered together a toggling priority flag alternates
// between them. Every output is driven from a register.
module sauria_axi_lite_to_obi #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic                     clk_i,
    input logic                     rst_i,
    sauria_axi_lite_to_obi_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int OFFSET_W = $clog2(BE_WIDTH);

    typedef enum logic [2:0] {
        IDLE, WREQ, WRSP, BRESP, RREQ, RRSP, RRESP
    } state_t;

    state_t state;
    logic   write_first;   // 0 = read wins a tie, 1 = write wins a tie
    logic   wr_cand;
    logic   rd_cand;

    // Clear the sub-word offset so the OBI side only sees word addresses.
    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] aligned;
        aligned = addr;
        aligned[OFFSET_W-1:0] = '0;
        return aligned;
    endfunction

    // A write needs address and data together; AW and W are never taken apart.
    assign wr_cand = bus.aw_valid_i & bus.w_valid_i;
    assign rd_cand = bus.ar_valid_i;

    // No error path exists, so both responses are permanently OKAY.
    assign bus.b_resp_o = 2'b00;
    assign bus.r_resp_o = 2'b00;

    // Transaction FSM: accept, issue on OBI, wait for response, answer on AXI.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            write_first     <= 1'b0;
            bus.aw_ready_o  <= 1'b0;
            bus.w_ready_o   <= 1'b0;
            bus.ar_ready_o  <= 1'b0;
            bus.b_valid_o   <= 1'b0;
            bus.r_valid_o   <= 1'b0;
            bus.r_data_o    <= '0;
            bus.obi_req_o   <= 1'b0;
            bus.obi_we_o    <= 1'b0;
            bus.obi_addr_o  <= '0;
            bus.obi_be_o    <= '0;
            bus.obi_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Ready is raised for the following cycle; AXI keeps the
                    // address/data stable until that handshake completes.
                    if (rd_cand && (!wr_cand || !write_first)) begin
                        bus.ar_ready_o <= 1'b1;
                        bus.obi_addr_o <= word_align(bus.ar_addr_i);
                        bus.obi_we_o   <= 1'b0;
                        bus.obi_be_o   <= '1;
                        state          <= RREQ;
                        if (wr_cand) begin
                            write_first <= 1'b1;
                        end
                    end else if (wr_cand) begin
                        bus.aw_ready_o  <= 1'b1;
                        bus.w_ready_o   <= 1'b1;
                        bus.obi_addr_o  <= word_align(bus.aw_addr_i);
                        bus.obi_we_o    <= 1'b1;
                        bus.obi_be_o    <= bus.w_strb_i;
                        bus.obi_wdata_o <= bus.w_data_i;
                        state           <= WREQ;
                        if (rd_cand) begin
                            write_first <= 1'b0;
                        end
                    end
                end
                WREQ: begin
                    // First cycle is the AW/W handshake; the request follows it.
                    if (bus.aw_ready_o) begin
                        bus.aw_ready_o <= 1'b0;
                        bus.w_ready_o  <= 1'b0;
                        bus.obi_req_o  <= 1'b1;
                    end else if (bus.obi_gnt_i) begin
                        bus.obi_req_o <= 1'b0;
                        state         <= WRSP;
                    end
                end
                WRSP: begin
                    if (bus.obi_rvalid_i) begin
                        bus.b_valid_o <= 1'b1;
                        state         <= BRESP;
                    end
                end
                BRESP: begin
                    if (bus.b_ready_i) begin
                        bus.b_valid_o <= 1'b0;
                        state         <= IDLE;
                    end
                end
                RREQ: begin
                    // First cycle is the AR handshake; the request follows it.
                    if (bus.ar_ready_o) begin
                        bus.ar_ready_o <= 1'b0;
                        bus.obi_req_o  <= 1'b1;
                    end else if (bus.obi_gnt_i) begin
                        bus.obi_req_o <= 1'b0;
                        state         <= RRSP;
                    end
                end
                RRSP: begin
                    if (bus.obi_rvalid_i) begin
                        bus.r_data_o  <= bus.obi_rdata_i;
                        bus.r_valid_o <= 1'b1;
                        state         <= RRESP;
                    end
                end
                RRESP: begin
                    if (bus.r_ready_i) begin
                        bus.r_valid_o <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sauria_axi_lite_to_obi.sv
// Directed bench for the AXI-Lite-to-OBI bridge. Inputs change 1 time unit
// after each rising edge and outputs are sampled at the same point, so
// "cycle N" below means the cycle that begins with the Nth edge after the
// stimulus is applied.
module tb_sauria_axi_lite_to_obi;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sauria_axi_lite_to_obi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sauria_axi_lite_to_obi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // OBI memory model: grants after gnt_delay request cycles, answers one
    // cycle after the grant. Manual mode hands the pins to the test.
    logic        obi_auto    = 1'b1;
    int          gnt_delay   = 0;
    logic [31:0] model_rdata = 32'h0;
    logic        man_gnt     = 1'b0;
    logic        man_rvalid  = 1'b0;
    logic [31:0] man_rdata   = 32'h0;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    assign bus.obi_gnt_i    = obi_auto ? m_gnt    : man_gnt;
    assign bus.obi_rvalid_i = obi_auto ? m_rvalid : man_rvalid;
    assign bus.obi_rdata_i  = obi_auto ? m_rdata  : man_rdata;

    initial begin
        logic rsp_pend;
        int   wait_cnt;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
        rsp_pend = 1'b0; wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            m_gnt = 1'b0;
            m_rvalid = 1'b0;
            if (rst || !obi_auto) begin
                rsp_pend = 1'b0;
                wait_cnt = 0;
            end else begin
                if (rsp_pend) begin
                    m_rvalid = 1'b1;
                    m_rdata  = model_rdata;
                    rsp_pend = 1'b0;
                end
                if (bus.obi_req_o) begin
                    if (wait_cnt >= gnt_delay) begin
                        m_gnt    = 1'b1;
                        rsp_pend = 1'b1;
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.aw_addr_i = '0; bus.aw_valid_i = 1'b0;
        bus.w_data_i = '0; bus.w_strb_i = '0; bus.w_valid_i = 1'b0;
        bus.b_ready_i = 1'b0;
        bus.ar_addr_i = '0; bus.ar_valid_i = 1'b0;
        bus.r_ready_i = 1'b0;
        man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = 32'h0;
        obi_auto = 1'b1; gnt_delay = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        total++;
        if ({bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o, bus.b_valid_o, bus.r_valid_o, bus.obi_req_o} !== 6'b0) begin
            bad++; $display("FAIL rst_handshake: got %b want 000000", {bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o, bus.b_valid_o, bus.r_valid_o, bus.obi_req_o});
        end
        total++;
        if (bus.obi_we_o !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", bus.obi_we_o); end
        total++;
        if (bus.obi_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", bus.obi_addr_o); end
        total++;
        if (bus.obi_be_o !== 4'h0) begin bad++; $display("FAIL rst_be: got %h want 0", bus.obi_be_o); end
        total++;
        if (bus.obi_wdata_o !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h want 0", bus.obi_wdata_o); end
        total++;
        if (bus.r_data_o !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.r_data_o); end
        total++;
        if ({bus.b_resp_o, bus.r_resp_o} !== 4'b0) begin bad++; $display("FAIL rst_resp: got %b want 0000", {bus.b_resp_o, bus.r_resp_o}); end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        do_reset();
        bus.b_ready_i = 1'b1;
        bus.aw_addr_i = 32'h0000_1003; bus.aw_valid_i = 1'b1;
        bus.w_data_i = 32'hDEAD_BEEF; bus.w_strb_i = 4'b0110; bus.w_valid_i = 1'b1;
        tick(); // cycle 0
        total++;
        if ({bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o} !== 3'b110) begin
            bad++; $display("FAIL wr_accept: got %b want 110", {bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o});
        end
        tick(); // cycle 1
        bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
        total++;
        if ({bus.obi_req_o, bus.obi_we_o, bus.aw_ready_o} !== 3'b110) begin
            bad++; $display("FAIL wr_req: got req/we/awready %b want 110", {bus.obi_req_o, bus.obi_we_o, bus.aw_ready_o});
        end
        total++;
        if (bus.obi_addr_o !== 32'h0000_1000) begin bad++; $display("FAIL wr_addr: got %h want 00001000", bus.obi_addr_o); end
        total++;
        if (bus.obi_be_o !== 4'b0110) begin bad++; $display("FAIL wr_be: got %b want 0110", bus.obi_be_o); end
        total++;
        if (bus.obi_wdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_wdata: got %h want deadbeef", bus.obi_wdata_o); end
        tick(); // cycle 2
        total++;
        if ({bus.obi_req_o, bus.b_valid_o} !== 2'b00) begin bad++; $display("FAIL wr_c2: got req/bvalid %b want 00", {bus.obi_req_o, bus.b_valid_o}); end
        tick(); // cycle 3
        total++;
        if ({bus.b_valid_o, bus.b_resp_o} !== 3'b100) begin bad++; $display("FAIL wr_bresp: got bvalid/bresp %b want 100", {bus.b_valid_o, bus.b_resp_o}); end
        tick(); // cycle 4
        total++;
        if (bus.b_valid_o !== 1'b0) begin bad++; $display("FAIL wr_bdone: got %b want 0", bus.b_valid_o); end
    endtask

    task automatic test_single_read();
        do_reset();
        gnt_delay = 4; model_rdata = 32'h1234_5678;
        bus.r_ready_i = 1'b1;
        bus.ar_addr_i = 32'h0000_0040; bus.ar_valid_i = 1'b1;
        tick(); // cycle 0
        total++;
        if ({bus.ar_ready_o, bus.aw_ready_o} !== 2'b10) begin bad++; $display("FAIL rd_accept: got %b want 10", {bus.ar_ready_o, bus.aw_ready_o}); end
        tick(); // cycle 1
        bus.ar_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({bus.obi_req_o, bus.obi_we_o, bus.obi_be_o, bus.obi_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h0000_0040}) begin
                bad++; $display("FAIL rd_req_hold[%0d]: got req=%b we=%b be=%h addr=%h want 1 0 f 00000040", i, bus.obi_req_o, bus.obi_we_o, bus.obi_be_o, bus.obi_addr_o);
            end
            tick();
        end
        // cycle 6: grant was in cycle 5
        total++;
        if ({bus.obi_req_o, bus.r_valid_o} !== 2'b00) begin bad++; $display("FAIL rd_after_gnt: got req/rvalid %b want 00", {bus.obi_req_o, bus.r_valid_o}); end
        tick(); // cycle 7
        total++;
        if ({bus.r_valid_o, bus.r_resp_o} !== 3'b100) begin bad++; $display("FAIL rd_rvalid: got rvalid/rresp %b want 100", {bus.r_valid_o, bus.r_resp_o}); end
        total++;
        if (bus.r_data_o !== 32'h1234_5678) begin bad++; $display("FAIL rd_data: got %h want 12345678", bus.r_data_o); end
        tick(); // cycle 8
        total++;
        if (bus.r_valid_o !== 1'b0) begin bad++; $display("FAIL rd_done: got %b want 0", bus.r_valid_o); end
    endtask

    task automatic test_arbitration();
        logic [3:0] order;
        int         n;
        int         overlap;
        do_reset();
        order = 4'b0; n = 0; overlap = 0;
        model_rdata = 32'h0F0F_0F0F;
        bus.b_ready_i = 1'b1; bus.r_ready_i = 1'b1;
        bus.aw_addr_i = 32'h0000_0200; bus.w_data_i = 32'hA5A5_A5A5; bus.w_strb_i = 4'hF;
        bus.ar_addr_i = 32'h0000_0300;
        bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1; bus.ar_valid_i = 1'b1;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            tick();
            if (bus.aw_ready_o && bus.ar_ready_o) overlap++;
            if (bus.ar_ready_o) begin
                order[n] = 1'b0; n++;
            end else if (bus.aw_ready_o) begin
                order[n] = 1'b1; n++;
            end
        end
        tick();
        bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0; bus.ar_valid_i = 1'b0;
        total++;
        if (n !== 4) begin bad++; $display("FAIL arb_count: got %0d accepts want 4", n); end
        total++;
        if (order !== 4'b1010) begin bad++; $display("FAIL arb_order: got %b want 1010 (bit0 first, 1=write)", order); end
        total++;
        if (overlap !== 0) begin bad++; $display("FAIL arb_overlap: got %0d cycles want 0", overlap); end
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_split_aw_w();
        do_reset();
        bus.b_ready_i = 1'b1;
        bus.aw_addr_i = 32'h0000_0500; bus.aw_valid_i = 1'b1;
        bus.w_data_i = 32'h1122_3344; bus.w_strb_i = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o, bus.obi_req_o} !== 4'b0) begin
                bad++; $display("FAIL split_wait[%0d]: got %b want 0000", i, {bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o, bus.obi_req_o});
            end
        end
        bus.w_valid_i = 1'b1;
        tick();
        total++;
        if ({bus.aw_ready_o, bus.w_ready_o} !== 2'b11) begin bad++; $display("FAIL split_accept: got %b want 11", {bus.aw_ready_o, bus.w_ready_o}); end
        tick();
        bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
        total++;
        if ({bus.obi_req_o, bus.obi_we_o, bus.obi_wdata_o} !== {2'b11, 32'h1122_3344}) begin
            bad++; $display("FAIL split_req: got req=%b we=%b wdata=%h want 1 1 11223344", bus.obi_req_o, bus.obi_we_o, bus.obi_wdata_o);
        end
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        model_rdata = 32'hCAFE_0001;
        bus.ar_addr_i = 32'h0000_0080; bus.ar_valid_i = 1'b1;
        tick(); // cycle 0
        total++;
        if (bus.ar_ready_o !== 1'b1) begin bad++; $display("FAIL bp_accept: got %b want 1", bus.ar_ready_o); end
        tick(); tick(); tick(); // cycle 3
        total++;
        if ({bus.r_valid_o, bus.r_data_o} !== {1'b1, 32'hCAFE_0001}) begin
            bad++; $display("FAIL bp_first: got rvalid=%b data=%h want 1 cafe0001", bus.r_valid_o, bus.r_data_o);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({bus.r_valid_o, bus.r_data_o, bus.ar_ready_o} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin
                bad++; $display("FAIL bp_hold[%0d]: got rvalid=%b data=%h arready=%b want 1 cafe0001 0", i, bus.r_valid_o, bus.r_data_o, bus.ar_ready_o);
            end
        end
        bus.r_ready_i = 1'b1;
        tick();
        total++;
        if ({bus.r_valid_o, bus.ar_ready_o} !== 2'b00) begin bad++; $display("FAIL bp_release: got rvalid/arready %b want 00", {bus.r_valid_o, bus.ar_ready_o}); end
        tick();
        total++;
        if (bus.ar_ready_o !== 1'b1) begin bad++; $display("FAIL bp_next_accept: got %b want 1", bus.ar_ready_o); end
        tick();
        bus.ar_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        obi_auto = 1'b0;
        bus.r_ready_i = 1'b1;
        bus.ar_addr_i = 32'h0000_0100; bus.ar_valid_i = 1'b1;
        tick(); // cycle 0: AR handshake
        tick(); // cycle 1: request, granted by hand
        bus.ar_valid_i = 1'b0;
        man_gnt = 1'b1;
        tick(); // cycle 2: waiting for the response
        man_gnt = 1'b0;
        total++;
        if ({bus.obi_req_o, bus.r_valid_o} !== 2'b00) begin bad++; $display("FAIL mid_rrsp: got req/rvalid %b want 00", {bus.obi_req_o, bus.r_valid_o}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o, bus.b_valid_o, bus.r_valid_o, bus.obi_req_o,
             bus.obi_we_o, bus.obi_addr_o, bus.obi_be_o, bus.obi_wdata_o, bus.r_data_o, bus.b_resp_o, bus.r_resp_o} !== '0) begin
            bad++; $display("FAIL mid_reset_vals: addr=%h be=%h rdata=%h ctl=%b want all zero", bus.obi_addr_o, bus.obi_be_o, bus.r_data_o,
                            {bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o, bus.b_valid_o, bus.r_valid_o, bus.obi_req_o, bus.obi_we_o});
        end
        man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
        tick();
        man_rvalid = 1'b0;
        total++;
        if (bus.r_valid_o !== 1'b0) begin bad++; $display("FAIL mid_stale_rvalid: got %b want 0", bus.r_valid_o); end
        tick();
        total++;
        if ({bus.r_valid_o, bus.r_data_o} !== {1'b0, 32'h0}) begin bad++; $display("FAIL mid_stale_data: got rvalid=%b data=%h want 0 0", bus.r_valid_o, bus.r_data_o); end
        obi_auto = 1'b1; gnt_delay = 0; model_rdata = 32'h5A5A_0042;
        bus.ar_addr_i = 32'h0000_0104; bus.ar_valid_i = 1'b1;
        tick(); // cycle 0
        total++;
        if (bus.ar_ready_o !== 1'b1) begin bad++; $display("FAIL mid_re_accept: got %b want 1", bus.ar_ready_o); end
        tick(); // cycle 1
        bus.ar_valid_i = 1'b0;
        total++;
        if ({bus.obi_req_o, bus.obi_addr_o} !== {1'b1, 32'h0000_0104}) begin bad++; $display("FAIL mid_re_req: got req=%b addr=%h want 1 00000104", bus.obi_req_o, bus.obi_addr_o); end
        tick(); // cycle 2
        tick(); // cycle 3
        total++;
        if ({bus.r_valid_o, bus.r_data_o} !== {1'b1, 32'h5A5A_0042}) begin bad++; $display("FAIL mid_re_data: got rvalid=%b data=%h want 1 5a5a0042", bus.r_valid_o, bus.r_data_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_arbitration();
        test_split_aw_w();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
